// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB loopback subsystem: the master FSM
// state encoding, the strobe width and the byte-lane width used for strobed
// writes.
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int STRB_WIDTH = 4;
    localparam int BYTE_WIDTH = 8;

endpackage : apb_pkg

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB3 slave backed by a small word-addressed register memory.
//   - Decodes an error for unaligned addresses or word indexes beyond the
//     memory depth.
//   - Inserts WAIT_STATES cycles of pready=0 in every ACCESS phase.
//   - Applies byte-strobed writes at the end of the completing ACCESS cycle.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   psel, penable, pwrite    APB control from the master
//   paddr, pwdata, pstrb     APB address, write data, byte strobes
//   pready                   transfer completes this cycle
//   prdata                   read data (0 unless completing an error-free read)
//   pslverr                  error flag, only in the completing ACCESS cycle
// -----------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];
    logic [2:0]            wait_cnt_q;
    logic [2:0]            wait_cnt_d;

    logic             setup_phase;
    logic             access_phase;
    logic             addr_err;
    logic [IDX_W-1:0] idx;

    assign setup_phase  = psel && !penable;
    assign access_phase = psel && penable;
    assign idx          = paddr[IDX_W+1:2];

    // The full shifted address is compared so that any set bit above the
    // index field flags an out-of-range access instead of aliasing.
    assign addr_err = (paddr[1:0] != 2'b00) ||
                      ((paddr >> 2) >= ADDR_WIDTH'(MEM_DEPTH));

    assign pready  = access_phase && (wait_cnt_q == 3'(WAIT_STATES));
    assign pslverr = pready && addr_err;
    assign prdata  = (pready && !pwrite && !addr_err) ? mem_q[idx] : '0;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        wait_cnt_d = wait_cnt_q;
        if (setup_phase) begin
            wait_cnt_d = 3'd0;
        end else if (access_phase && !pready) begin
            wait_cnt_d = wait_cnt_q + 3'd1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (pready && pwrite && !addr_err) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (pstrb[b]) begin
                    mem_d[idx][b*BYTE_WIDTH +: BYTE_WIDTH] = pwdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 3'd0;
            // NOTE: the memory is deliberately cleared by reset; this forces a
            // flop array rather than a RAM macro, which suits this tiny depth.
            mem_q      <= '{default: '0};
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule : apb_slave_mem

// File: rtl/apb_loopback.sv
// -----------------------------------------------------------------------------
// apb_loopback
// Self-contained APB3 subsystem: a master FSM turns single command requests
// into APB transfers on an internal bus answered by apb_slave_mem. All bus
// signals are exported for observation.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (accepted in IDLE)
//   cmd_write, cmd_addr, cmd_wdata,
//   cmd_strb                         command contents
//   rsp_valid                        one-cycle completion pulse
//   rsp_rdata, rsp_slverr            read data (0 for writes/errors), error
//   psel .. pstrb                    observed APB bus
// -----------------------------------------------------------------------------
module apb_loopback
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic [STRB_WIDTH-1:0] pstrb
);

    apb_state_e            state_q,      state_d;
    logic                  psel_q,       psel_d;
    logic                  penable_q,    penable_d;
    logic                  pwrite_q,     pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,      paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,     pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q,      pstrb_d;
    logic                  rsp_valid_q,  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,  rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d;

    // The bus registers double as the command capture: the command is copied
    // straight into paddr/pwdata/pstrb/pwrite on acceptance and held there
    // until the next command.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_strb;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d      = IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = prdata;
                    rsp_slverr_d = pslverr;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;

    apb_slave_mem #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH),
        .WAIT_STATES (WAIT_STATES)
    ) u_slave (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel_q),
        .penable (penable_q),
        .pwrite  (pwrite_q),
        .paddr   (paddr_q),
        .pwdata  (pwdata_q),
        .pstrb   (pstrb_q),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

endmodule : apb_loopback

// File: tb/tb_apb_loopback.sv
// -----------------------------------------------------------------------------
// tb_apb_loopback
// Directed bench for apb_loopback. Two instances share the clock: dut0 with
// WAIT_STATES=0 and dut3 with WAIT_STATES=3. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_loopback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- dut0 (no wait states) ----------------
    logic        rst0, cmd_valid0, cmd_ready0, cmd_write0;
    logic [31:0] cmd_addr0, cmd_wdata0;
    logic [3:0]  cmd_strb0;
    logic        rsp_valid0, rsp_slverr0;
    logic [31:0] rsp_rdata0;
    logic        psel0, penable0, pwrite0, pready0, pslverr0;
    logic [31:0] paddr0, pwdata0, prdata0;
    logic [3:0]  pstrb0;

    apb_loopback #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst0),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write0),
        .cmd_addr(cmd_addr0), .cmd_wdata(cmd_wdata0), .cmd_strb(cmd_strb0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_slverr(rsp_slverr0),
        .psel(psel0), .penable(penable0), .pwrite(pwrite0), .pready(pready0),
        .pslverr(pslverr0), .paddr(paddr0), .pwdata(pwdata0), .prdata(prdata0),
        .pstrb(pstrb0)
    );

    // ---------------- dut3 (three wait states) ----------------
    logic        rst3, cmd_valid3, cmd_ready3, cmd_write3;
    logic [31:0] cmd_addr3, cmd_wdata3;
    logic [3:0]  cmd_strb3;
    logic        rsp_valid3, rsp_slverr3;
    logic [31:0] rsp_rdata3;
    logic        psel3, penable3, pwrite3, pready3, pslverr3;
    logic [31:0] paddr3, pwdata3, prdata3;
    logic [3:0]  pstrb3;

    apb_loopback #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst3),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
        .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3), .cmd_strb(cmd_strb3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_slverr(rsp_slverr3),
        .psel(psel3), .penable(penable3), .pwrite(pwrite3), .pready(pready3),
        .pslverr(pslverr3), .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3),
        .pstrb(pstrb3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer on dut0, checking the N / N+1 / N+2 / N+3 timeline.
    task automatic run0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
        cmd_valid0 = 1'b1;
        cmd_write0 = wr;
        cmd_addr0  = addr;
        cmd_wdata0 = wdata;
        cmd_strb0  = strb;
        check({tag, "_ready"}, 32'(cmd_ready0), 32'd1);
        tick();                                       // N+1: SETUP
        cmd_valid0 = 1'b0;
        check({tag, "_setup_psel"},    32'(psel0),    32'd1);
        check({tag, "_setup_penable"}, 32'(penable0), 32'd0);
        check({tag, "_setup_paddr"},   paddr0,        addr);
        check({tag, "_setup_pwrite"},  32'(pwrite0),  32'(wr));
        tick();                                       // N+2: ACCESS
        check({tag, "_acc_penable"}, 32'(penable0), 32'd1);
        check({tag, "_acc_pready"},  32'(pready0),  32'd1);
        check({tag, "_acc_pslverr"}, 32'(pslverr0), 32'(exp_err));
        check({tag, "_acc_rsp"},     32'(rsp_valid0), 32'd0);
        tick();                                       // N+3: response
        check({tag, "_rsp_valid"},  32'(rsp_valid0),  32'd1);
        check({tag, "_rsp_rdata"},  rsp_rdata0,       exp_rdata);
        check({tag, "_rsp_slverr"}, 32'(rsp_slverr0), 32'(exp_err));
        check({tag, "_rsp_psel"},   32'(psel0),       32'd0);
        check({tag, "_rsp_ready"},  32'(cmd_ready0),  32'd1);
    endtask

    // One full transfer on dut3: ACCESS lasts four cycles, response at N+6.
    task automatic run3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag);
        cmd_valid3 = 1'b1;
        cmd_write3 = wr;
        cmd_addr3  = addr;
        cmd_wdata3 = wdata;
        cmd_strb3  = 4'hF;
        check({tag, "_ready"}, 32'(cmd_ready3), 32'd1);
        tick();                                       // N+1: SETUP
        cmd_valid3 = 1'b0;
        check({tag, "_setup_psel"},    32'(psel3),    32'd1);
        check({tag, "_setup_penable"}, 32'(penable3), 32'd0);
        for (int k = 0; k < 4; k++) begin             // N+2 .. N+5: ACCESS
            tick();
            check({tag, "_acc_penable"}, 32'(penable3),   32'd1);
            check({tag, "_acc_pready"},  32'(pready3),    (k == 3) ? 32'd1 : 32'd0);
            check({tag, "_acc_paddr"},   paddr3,          addr);
            check({tag, "_acc_rsp"},     32'(rsp_valid3), 32'd0);
        end
        tick();                                       // N+6: response
        check({tag, "_rsp_valid"}, 32'(rsp_valid3), 32'd1);
        check({tag, "_rsp_rdata"}, rsp_rdata3,      exp_rdata);
        check({tag, "_rsp_penable"}, 32'(penable3), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];

    initial begin
        b2b_addr = '{32'h20, 32'h24, 32'h28, 32'h2C};
        b2b_data = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};

        rst0 = 1'b1; cmd_valid0 = 1'b0; cmd_write0 = 1'b0;
        cmd_addr0 = '0; cmd_wdata0 = '0; cmd_strb0 = '0;
        rst3 = 1'b1; cmd_valid3 = 1'b0; cmd_write3 = 1'b0;
        cmd_addr3 = '0; cmd_wdata3 = '0; cmd_strb3 = '0;
        tick();
        tick();

        // Reset state.
        check("rst_cmd_ready", 32'(cmd_ready0), 32'd1);
        check("rst_psel",      32'(psel0),      32'd0);
        check("rst_penable",   32'(penable0),   32'd0);
        check("rst_paddr",     paddr0,          32'd0);
        check("rst_pwdata",    pwdata0,         32'd0);
        check("rst_pstrb",     32'(pstrb0),     32'd0);
        check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
        check("rst_rsp_rdata", rsp_rdata0,      32'd0);
        check("rst3_psel",     32'(psel3),      32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        tick();

        // Full write then read back.
        run0(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr4");
        check("wr4_pwdata_hold", pwdata0, 32'hDEAD_BEEF);
        run0(1'b0, 32'h4, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd4");

        // Strobed write: only bytes 0 and 2 change.
        run0(1'b1, 32'h4, 32'h1122_3344, 4'h5, 32'h0, 1'b0, "wr4_strb");
        run0(1'b0, 32'h4, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, "rd4_strb");

        // Error cases: out of range read, unaligned writes, memory untouched.
        run0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor");
        run0(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_unal2");
        run0(1'b1, 32'h5, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_unal5");
        run0(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, "rd0_after_err");
        run0(1'b0, 32'h4, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, "rd4_after_err");

        // Last valid word.
        run0(1'b1, 32'h3C, 32'h5A5A_0F0F, 4'hF, 32'h0, 1'b0, "wr_last");
        run0(1'b0, 32'h3C, 32'h0, 4'h0, 32'h5A5A_0F0F, 1'b0, "rd_last");

        // Back-to-back writes with cmd_valid held high: accepted every 3 cycles.
        cmd_valid0 = 1'b1;
        cmd_write0 = 1'b1;
        cmd_strb0  = 4'hF;
        cmd_addr0  = b2b_addr[0];
        cmd_wdata0 = b2b_data[0];
        for (int i = 0; i < 4; i++) begin
            check("b2b_accept_ready", 32'(cmd_ready0), 32'd1);
            tick();
            check("b2b_setup_paddr", paddr0, b2b_addr[i]);
            check("b2b_setup_ready", 32'(cmd_ready0), 32'd0);
            if (i < 3) begin
                cmd_addr0  = b2b_addr[i+1];
                cmd_wdata0 = b2b_data[i+1];
            end else begin
                cmd_valid0 = 1'b0;
            end
            tick();
            check("b2b_access_ready", 32'(cmd_ready0), 32'd0);
            tick();
            check("b2b_rsp_valid", 32'(rsp_valid0), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            run0(1'b0, b2b_addr[i], 32'h0, 4'h0, b2b_data[i], 1'b0, "b2b_rd");
        end

        // Wait-state instance.
        run3(1'b1, 32'h10, 32'hCAFE_F00D, 32'h0, "ws3_wr");
        run3(1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, "ws3_rd");

        // Reset in the ACCESS cycle of a write to 0x8.
        run0(1'b1, 32'h8, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "wr8_pre");
        cmd_valid0 = 1'b1;
        cmd_write0 = 1'b1;
        cmd_addr0  = 32'h8;
        cmd_wdata0 = 32'hAAAA_5555;
        cmd_strb0  = 4'hF;
        tick();
        cmd_valid0 = 1'b0;
        tick();
        check("rst_mid_access", 32'(penable0), 32'd1);
        rst0 = 1'b1;
        tick();
        check("rst_mid_rsp_valid",  32'(rsp_valid0),  32'd0);
        check("rst_mid_psel",       32'(psel0),       32'd0);
        check("rst_mid_penable",    32'(penable0),    32'd0);
        check("rst_mid_pwrite",     32'(pwrite0),     32'd0);
        check("rst_mid_paddr",      paddr0,           32'd0);
        check("rst_mid_pwdata",     pwdata0,          32'd0);
        check("rst_mid_pstrb",      32'(pstrb0),      32'd0);
        check("rst_mid_prdata",     prdata0,          32'd0);
        check("rst_mid_pslverr",    32'(pslverr0),    32'd0);
        check("rst_mid_rsp_rdata",  rsp_rdata0,       32'd0);
        check("rst_mid_rsp_slverr", 32'(rsp_slverr0), 32'd0);
        rst0 = 1'b0;
        tick();
        check("rst_mid_no_rsp", 32'(rsp_valid0), 32'd0);
        check("rst_mid_ready",  32'(cmd_ready0), 32'd1);
        run0(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, "rd8_after_rst");
        run0(1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, "rd4_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_apb_loopback
